// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Frames a UART byte stream (sync, 16-bit word count, payload, XOR checksum),
// assembles little-endian 32-bit words and drives the instruction RAM write
// port. busy/done/error let the top level hold the core in reset until the
// program image is in place.
module imem_loader #(
  parameter int         word_size = 32,
  parameter int         ROM_SIZE  = 256,
  parameter int         BASE_WORD = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic                 o_we,
  output logic [word_size-1:0] o_waddr,
  output logic [31:0]          o_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [15:0]          o_word_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_ready_q;
  logic                 accept;
  logic [15:0]          len_q;
  logic [15:0]          n_len;
  logic                 len_overflow;
  logic                 last_word;
  logic [1:0]           lane_q;
  logic [23:0]          word_q;
  logic [31:0]          wdata_q;
  logic [word_size-1:0] waddr_q;
  logic [15:0]          word_count_q;
  logic [7:0]           csum_q;

  // States in which the loader takes bytes from the receiver.
  function automatic logic is_rx_state(input state_e s);
    return (s == S_SYNC) || (s == S_LEN_LO) || (s == S_LEN_HI) ||
           (s == S_DATA) || (s == S_CSUM);
  endfunction

  assign accept       = i_rx_valid && rx_ready_q;
  // Full 16-bit count as it stands once the high byte is on the bus.
  assign n_len        = {i_rx_data, len_q[7:0]};
  // Compared in 32 bits so BASE_WORD + N can never wrap.
  assign len_overflow = ({16'd0, n_len} + 32'(BASE_WORD)) > 32'(ROM_SIZE);
  assign last_word    = (word_count_q + 16'd1) == len_q;

  // State register; ready is registered from the next state so it never
  // depends combinationally on i_rx_valid.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= is_rx_state(state_d);
    end
  end

  // Next-state logic for the frame parser.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (accept && (i_rx_data == SYNC_BYTE)) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          if (n_len == 16'd0)    state_d = S_CSUM;
          else if (len_overflow) state_d = S_ERROR;
          else                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (lane_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) state_d = (i_rx_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    o_we    = (state_q == S_WRITE);
    o_busy  = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    o_done  = (state_q == S_DONE);
    o_error = (state_q == S_ERROR);
  end

  // Datapath: length capture, word assembly, checksum and write counter.
  // The write address/data registers load only on the 4th byte, so they stay
  // stable between write pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      wdata_q      <= '0;
      waddr_q      <= '0;
      word_count_q <= '0;
      csum_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            word_count_q <= '0;
            csum_q       <= '0;
            lane_q       <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) len_q[7:0] <= i_rx_data;
        end
        S_LEN_HI: begin
          if (accept) len_q <= n_len;
        end
        S_DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ i_rx_data;
            lane_q <= lane_q + 2'd1;
            unique case (lane_q)
              2'd0: word_q[7:0]   <= i_rx_data;
              2'd1: word_q[15:8]  <= i_rx_data;
              2'd2: word_q[23:16] <= i_rx_data;
              default: begin
                wdata_q <= {i_rx_data, word_q};
                waddr_q <= word_size'((32'(BASE_WORD) + 32'(word_count_q)) << 2);
              end
            endcase
          end
        end
        S_WRITE: begin
          word_count_q <= word_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames with a write
// scoreboard, plus hand-written reset, long-load and restart sequences.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_we;
  logic [31:0] o_waddr;
  logic [31:0] o_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_count;

  imem_loader #(
    .word_size(32),
    .ROM_SIZE (256),
    .BASE_WORD(1),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] last_waddr = '0;

  typedef struct {
    logic [7:0]  b [15];
    int          nbytes;
    int          max_gap;
    int          nwr;
    logic [31:0] addr [2];
    logic [31:0] data [2];
    bit          exp_done;
    bit          exp_error;
    int          exp_count;
  } vec_t;

  vec_t v [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (o_we === 1'b1) begin
      check("ready_low_in_write", {31'd0, o_rx_ready}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_waddr, o_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", o_waddr, e.addr);
        check("write_data", o_wdata, e.data);
      end
      last_waddr = o_waddr;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Offer one byte from a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (o_rx_ready) begin
        @(posedge i_clk);
        ok = 1'b1;
      end
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_accept_timeout: byte %02h got no ready expected accept within 64 cycles", b);
    end
  endtask

  task automatic apply_vec(input int i);
    wr_t w;
    for (int k = 0; k < v[i].nwr; k++) begin
      w.addr = v[i].addr[k];
      w.data = v[i].data[k];
      sb.push_back(w);
    end
    do_start();
    for (int k = 0; k < v[i].nbytes; k++) begin
      send_byte(v[i].b[k]);
      if (v[i].max_gap > 0) repeat ($urandom_range(v[i].max_gap, 1)) @(negedge i_clk);
    end
    @(negedge i_clk);
    check($sformatf("v%0d_done", i),  {31'd0, o_done},  {31'd0, v[i].exp_done});
    check($sformatf("v%0d_error", i), {31'd0, o_error}, {31'd0, v[i].exp_error});
    check($sformatf("v%0d_count", i), {16'd0, o_word_count}, 32'(v[i].exp_count));
    check($sformatf("v%0d_busy", i),  {31'd0, o_busy},  32'd0);
    check($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, o_rx_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, o_we},       32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},     32'd0);
    check({tag, "_done"},  {31'd0, o_done},     32'd0);
    check({tag, "_error"}, {31'd0, o_error},    32'd0);
    check({tag, "_count"}, {16'd0, o_word_count}, 32'd0);
  endtask

  initial begin
    logic [7:0]  csum;
    logic [31:0] word;
    wr_t         w;

    // Nominal 2-word load.
    v[0].b = '{8'hA5, 8'h02, 8'h00, 8'hB7, 8'h15, 8'h00, 8'hF0, 8'h13,
               8'h0C, 8'h1C, 8'h00, 8'h51, 8'h00, 8'h00, 8'h00};
    v[0].nbytes = 12; v[0].max_gap = 0; v[0].nwr = 2;
    v[0].addr = '{32'h4, 32'h8}; v[0].data = '{32'hF00015B7, 32'h001C0C13};
    v[0].exp_done = 1; v[0].exp_error = 0; v[0].exp_count = 2;
    // Sync hunt with stalls between bytes.
    v[1].b = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h00, 8'hB7, 8'h15,
               8'h00, 8'hF0, 8'h13, 8'h0C, 8'h1C, 8'h00, 8'h51};
    v[1].nbytes = 15; v[1].max_gap = 5; v[1].nwr = 2;
    v[1].addr = '{32'h4, 32'h8}; v[1].data = '{32'hF00015B7, 32'h001C0C13};
    v[1].exp_done = 1; v[1].exp_error = 0; v[1].exp_count = 2;
    // N = 0x0100 overflows 256-word memory with BASE_WORD = 1.
    v[2].b = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    v[2].nbytes = 3; v[2].max_gap = 0; v[2].nwr = 0;
    v[2].addr = '{32'h0, 32'h0}; v[2].data = '{32'h0, 32'h0};
    v[2].exp_done = 0; v[2].exp_error = 1; v[2].exp_count = 0;
    // Empty image: N = 0, checksum 00.
    v[3].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    v[3].nbytes = 4; v[3].max_gap = 0; v[3].nwr = 0;
    v[3].addr = '{32'h0, 32'h0}; v[3].data = '{32'h0, 32'h0};
    v[3].exp_done = 1; v[3].exp_error = 0; v[3].exp_count = 0;
    // Bad checksum: writes still happen, then error.
    v[4].b = '{8'hA5, 8'h02, 8'h00, 8'hB7, 8'h15, 8'h00, 8'hF0, 8'h13,
               8'h0C, 8'h1C, 8'h00, 8'h52, 8'h00, 8'h00, 8'h00};
    v[4].nbytes = 12; v[4].max_gap = 0; v[4].nwr = 2;
    v[4].addr = '{32'h4, 32'h8}; v[4].data = '{32'hF00015B7, 32'h001C0C13};
    v[4].exp_done = 0; v[4].exp_error = 1; v[4].exp_count = 2;

    i_rst = 1'b1; i_start = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0;

    // Reset values, then bytes without i_start are never taken.
    #12;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    i_rx_data  = 8'hA5;
    i_rx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("no_start_ready", {31'd0, o_rx_ready}, 32'd0);
    end
    i_rx_valid = 1'b0;
    check("no_start_busy", {31'd0, o_busy}, 32'd0);

    for (int i = 0; i < 5; i++) apply_vec(i);

    // i_start after an error clears the sticky flags and the count.
    do_start();
    check("restart_error", {31'd0, o_error}, 32'd0);
    check("restart_done",  {31'd0, o_done},  32'd0);
    check("restart_count", {16'd0, o_word_count}, 32'd0);
    check("restart_busy",  {31'd0, o_busy},  32'd1);
    check("restart_ready", {31'd0, o_rx_ready}, 32'd1);

    // Reset asserted mid-clock: outputs drop without waiting for an edge.
    #2 i_rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Largest legal image: 255 words, last one at 0x3FC.
    csum = 8'h00;
    for (int k = 0; k < 255; k++) begin
      w.addr = 32'((k + 1) * 4);
      w.data = 32'(k) * 32'h9E3779B9 + 32'h13;
      sb.push_back(w);
    end
    do_start();
    send_byte(8'hA5);
    send_byte(8'hFF);
    send_byte(8'h00);
    for (int k = 0; k < 255; k++) begin
      word = 32'(k) * 32'h9E3779B9 + 32'h13;
      for (int j = 0; j < 4; j++) begin
        send_byte(word[j*8 +: 8]);
        csum = csum ^ word[j*8 +: 8];
      end
      if (k == 0) check("write_latency", {31'd0, o_we}, 32'd1);
    end
    send_byte(csum);
    @(negedge i_clk);
    check("max_done",      {31'd0, o_done}, 32'd1);
    check("max_count",     {16'd0, o_word_count}, 32'd255);
    check("max_last_addr", last_waddr, 32'h3FC);
    check("max_sb_empty",  32'(sb.size()), 32'd0);

    // Reset after two payload bytes of the first word: nothing is written.
    do_start();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hB7);
    send_byte(8'h15);
    #2 i_rst = 1'b1;
    #1 check_all_zero("mid_data_reset");
    repeat (3) @(negedge i_clk);
    check("mid_data_no_write", {31'd0, o_we}, 32'd0);
    i_rst = 1'b0;
    apply_vec(0);

    repeat (2) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory.
- Takes a byte stream from the UART receiver over a valid/ready handshake and frames it.
- Assembles little-endian 32-bit instruction words and drives the instruction RAM write port.
- Reports busy/done/error so the top level holds the core in reset until the load completes.

Parameters:
- word_size, 32, instruction/address width (write data fixed at 32 bits)
- ROM_SIZE, 256, instruction memory depth in words
- BASE_WORD, 1, first word index written; 1 preserves the NOP at address 0 (SAFE_START layout)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  single-cycle pulse; begins a load (ignored while o_busy=1)
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  i_rx_data is valid
- o_rx_ready  output  1  loader accepts a byte this cycle
- o_we  output  1  instruction memory write enable, single-cycle pulse
- o_waddr  output  word_size  byte address of the write (word index * 4)
- o_wdata  output  32  instruction word to write
- o_busy  output  1  load in progress (state neither IDLE, DONE nor ERROR)
- o_done  output  1  sticky: load completed with good checksum
- o_error  output  1  sticky: length overflow or checksum mismatch
- o_word_count  output  16  words written in the current or last load

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal length/index/checksum cleared.
- Handshake: a byte is accepted only in a cycle where i_rx_valid && o_rx_ready.
  - o_rx_ready=1 only in SYNC, LEN_LO, LEN_HI, DATA and CSUM.
  - o_rx_ready is a registered function of state (no combinational path from i_rx_valid).
- Frame format: SYNC_BYTE, then N_lo, N_hi (N = word count, 16 bits), then 4*N payload bytes (LSB first per word), then CSUM.
  - CSUM = XOR of all payload bytes only.
- States and transitions:
  - IDLE: i_start -> SYNC. Entry clears o_done, o_error, o_word_count and the checksum.
  - DONE / ERROR: i_start -> SYNC, with the same clearing.
  - SYNC: an accepted byte equal to SYNC_BYTE -> LEN_LO. Any other byte is discarded and the state stays SYNC.
  - LEN_LO: accept byte -> LEN_HI.
  - LEN_HI: accept byte, then check N:
    - N==0 -> CSUM (expected checksum 0x00).
    - BASE_WORD+N > ROM_SIZE (17-bit compare, no wrap) -> ERROR.
    - Otherwise -> DATA.
  - DATA:
    - Each accepted byte shifts into byte lane [count] and XORs into the checksum.
    - The 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - o_we=1, o_waddr=(BASE_WORD+k)*4, o_wdata=assembled word.
    - o_word_count increments at the end of the cycle.
    - Then -> CSUM if k+1==N, else DATA.
  - CSUM: accept byte; equal to the running XOR -> DONE (o_done=1), else -> ERROR (o_error=1).
- Write latency: o_we is asserted in the cycle after the 4th byte of a word is accepted.
- Output validity: o_waddr and o_wdata are held stable when o_we=0, and are valid only while o_we=1.
- Gaps in i_rx_valid of any length are tolerated in every receiving state; state is held.
- i_start while busy: ignored, no restart.
- Sticky flags: o_done and o_error are mutually exclusive and remain set until the next i_start or reset.
- Reset mid-operation: immediate return to reset values. No o_we pulse may occur on or after the reset edge, and no partial word is written.
- Writes already completed before an ERROR are not undone; o_word_count reflects them.

Test Plan:
- Reset values: assert i_rst mid-clock -> all outputs 0 immediately. Release, then drive bytes without i_start -> o_rx_ready stays 0.
- Nominal 2-word load (BASE_WORD=1):
  - Stimulus: i_start; bytes A5 02 00 B7 15 00 F0 13 0C 1C 00 51.
  - Required: o_we at o_waddr=0x04 with 0xF00015B7, then at 0x08 with 0x001C0C13.
  - End state: o_done=1, o_error=0, o_word_count=2.
  - Also: o_rx_ready=0 in each WRITE cycle.
- Sync hunt and stalls: bytes 00 FF 13 precede A5, with 1–5 idle cycles between bytes -> same writes and result as the nominal load.
- Length bounds:
  - N=0x0100 -> ERROR right after LEN_HI, zero writes, o_word_count=0.
  - N=0x00FF -> accepted; the last write lands at o_waddr=0x3FC.
  - N=0 followed by CSUM 00 -> o_done=1 with no o_we.
- Bad checksum: nominal frame with CSUM=0x52 -> both writes occur, then o_error=1, o_done=0, o_word_count=2. A following i_start clears both flags.
- Reset mid-DATA: assert i_rst after 2 payload bytes of word 1 -> no o_we, outputs 0. A fresh nominal load then succeeds.
